ad5662_dac_writer: RTL and testbench

Serial write engine for the AD5662 16-bit reference-trim DAC that steers the 40 MHz clock oscillator. It sits directly downstream of the reference-clock PLL loop filter: it accepts one 16-bit DAC code per AXI-stream-style beat and drives the CLK_40M_DAC_nSYNC, CLK_40M_DAC_SCLK and CLK_40M_DAC_DIN pins with a complete 24-bit AD5662 frame. It generates its own divided serial clock, enforces the inter-frame nSYNC gap, and backpressures the loop while a frame is in flight.

---
 rtl/ad5662_dac_writer.sv | 129 ++++++++++++
 tb/tb_ad5662_dac_writer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad5662_dac_writer.sv
// Serial write engine for the AD5662 reference-trim DAC: one 16-bit code per beat, framed as a
// 24-bit word on nSYNC/SCLK/DIN with a divided serial clock and an enforced inter-frame gap.
module ad5662_dac_writer #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned SYNC_GAP = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] dac_tdata,
    input  logic [1:0]  dac_pd,
    input  logic        dac_tvalid,
    output logic        dac_tready,
    output logic        sclk,
    output logic        mosi,
    output logic        sync_n,
    output logic        busy
);

    localparam int unsigned MaxLen = (CLK_DIV > SYNC_GAP) ? CLK_DIV : SYNC_GAP;
    localparam int unsigned PhW    = (MaxLen > 1) ? $clog2(MaxLen) : 1;
    localparam logic [PhW-1:0] DivLast = PhW'(CLK_DIV - 1);
    localparam logic [PhW-1:0] GapLast = PhW'(SYNC_GAP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLow,
        StHigh,
        StGap
    } state_e;

    state_e         state_q, state_d;
    logic [PhW-1:0] phase_q, phase_d;
    logic [4:0]     bit_q, bit_d;
    logic [23:0]    shift_q, shift_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            phase_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + PhW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            StIdle: begin
                phase_d = '0;
                bit_d   = '0;
                if (dac_tvalid) begin
                    state_d = StSetup;
                    shift_d = {6'b0, dac_pd, dac_tdata};
                end
            end
            StSetup: begin
                if (phase_q == DivLast) begin
                    phase_d = '0;
                    state_d = StLow;
                end
            end
            StLow: begin
                if (phase_q == DivLast) begin
                    phase_d = '0;
                    bit_d   = bit_q + 5'd1;
                    // After the 24th low phase sclk returns high together with sync_n rising,
                    // which keeps sync_n low for exactly 48 half-periods.
                    if (bit_q == 5'd23) begin
                        state_d = StGap;
                    end else begin
                        state_d = StHigh;
                        shift_d = {shift_q[22:0], 1'b0};
                    end
                end
            end
            StHigh: begin
                if (phase_q == DivLast) begin
                    phase_d = '0;
                    state_d = StLow;
                end
            end
            StGap: begin
                if (phase_q == GapLast) begin
                    phase_d = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                phase_d = '0;
            end
        endcase
    end

    // Outputs decode registered state only; no input reaches a pin combinationally.
    always_comb begin
        sync_n     = 1'b1;
        sclk       = 1'b1;
        mosi       = 1'b0;
        dac_tready = 1'b0;
        busy       = 1'b1;
        case (state_q)
            StIdle: begin
                dac_tready = 1'b1;
                busy       = 1'b0;
            end
            StSetup, StHigh: begin
                sync_n = 1'b0;
                mosi   = shift_q[23];
            end
            StLow: begin
                sync_n = 1'b0;
                sclk   = 1'b0;
                mosi   = shift_q[23];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ad5662_dac_writer.sv
// Randomized self-checking bench for ad5662_dac_writer against a cycle-timing reference model
// derived from the frame timing rules.
module tb_ad5662_dac_writer;

    localparam int D  = 2;
    localparam int SG = 4;
    localparam int FL = 48 * D;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] dac_tdata;
    logic [1:0]  dac_pd;
    logic        dac_tvalid;
    logic        dac_tready, sclk, mosi, sync_n, busy;

    ad5662_dac_writer #(
        .CLK_DIV  (D),
        .SYNC_GAP (SG)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dac_tdata  (dac_tdata),
        .dac_pd     (dac_pd),
        .dac_tvalid (dac_tvalid),
        .dac_tready (dac_tready),
        .sclk       (sclk),
        .mosi       (mosi),
        .sync_n     (sync_n),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int sends    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model and frame monitor, sampled on the falling clock edge.
    bit          acc_valid = 0;
    int          acc_cyc = 0;
    logic [23:0] acc_frame;
    int          model_err = 0;
    int          acc_q[$];
    logic        prev_sclk = 1'b1, prev_sync = 1'b1;
    logic [23:0] cap;
    int          cap_edges, low_len, first_edge, cur_gap;
    int          high_run = 0, edges_now = 0, frames_done = 0;
    logic [23:0] cap_q[$];
    int          edges_q[$], len_q[$], first_q[$], gap_q[$];

    always @(negedge clk) begin
        bit   in_busy;
        logic e_sync, e_sclk, e_mosi;
        int   rel, j, idx;
        if (!reset_n) begin
            acc_valid = 0;
            prev_sclk = 1'b1;
            prev_sync = 1'b1;
            edges_now = 0;
            high_run  = 0;
        end else begin
            in_busy = acc_valid && (cyc >= acc_cyc + 1) && (cyc <= acc_cyc + FL + SG);
            e_sync  = 1'b1;
            e_sclk  = 1'b1;
            e_mosi  = 1'b0;
            if (acc_valid && (cyc >= acc_cyc + 1) && (cyc <= acc_cyc + FL)) begin
                rel    = cyc - acc_cyc - 1;
                e_sync = 1'b0;
                if (rel < D) begin
                    idx = 0;
                end else begin
                    j      = (rel - D) / D;
                    e_sclk = (j % 2) != 0;
                    idx    = (j + 1) / 2;
                end
                e_mosi = acc_frame[23-idx];
            end
            if ({sync_n, sclk, mosi, busy, dac_tready} !==
                {e_sync, e_sclk, e_mosi, in_busy, !in_busy}) model_err++;
            if (dac_tvalid && !in_busy) begin
                acc_valid = 1;
                acc_cyc   = cyc;
                acc_frame = {6'b0, dac_pd, dac_tdata};
                acc_q.push_back(cyc);
            end
            if (prev_sync && !sync_n) begin
                cap        = '0;
                cap_edges  = 0;
                low_len    = 0;
                first_edge = -1;
                cur_gap    = high_run;
                edges_now  = 0;
            end
            if (!sync_n) begin
                low_len++;
                if (prev_sclk && !sclk) begin
                    cap = {cap[22:0], mosi};
                    cap_edges++;
                    edges_now++;
                    if (first_edge < 0) first_edge = cyc - acc_cyc;
                end
            end
            if (!prev_sync && sync_n) begin
                cap_q.push_back(cap);
                edges_q.push_back(cap_edges);
                len_q.push_back(low_len);
                first_q.push_back(first_edge);
                gap_q.push_back(cur_gap);
                frames_done++;
                high_run = 0;
            end
            if (sync_n) high_run++;
            prev_sclk = sclk;
            prev_sync = sync_n;
        end
    end

    task automatic send(input logic [15:0] d, input logic [1:0] p, input bit hold);
        int t;
        @(posedge clk);
        #1;
        dac_tdata  = d;
        dac_pd     = p;
        dac_tvalid = 1'b1;
        sends++;
        t = 0;
        @(negedge clk);
        while (!dac_tready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!dac_tready) check_eq("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!hold) dac_tvalid = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input logic [23:0] exp, output int gap);
        int t;
        t   = 0;
        gap = -1;
        while (cap_q.size() == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (cap_q.size() == 0) begin
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check_eq({tag, "_frame"}, 32'(cap_q.pop_front()), 32'(exp));
            check_eq({tag, "_edges"}, 32'(edges_q.pop_front()), 32'd24);
            check_eq({tag, "_synclow"}, 32'(len_q.pop_front()), 32'(FL));
            check_eq({tag, "_first"}, 32'(first_q.pop_front()), 32'(1 + D));
            gap = gap_q.pop_front();
        end
    endtask

    task automatic wait_edges(input int n);
        int t;
        t = 0;
        while (edges_now < n && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (edges_now < n) check_eq("edge_timeout", 32'(edges_now), 32'(n));
    endtask

    initial begin
        logic [15:0] d;
        logic [1:0]  p;
        bit          hold;
        int          gap;
        int          done_before;
        logic [23:0] exp_q[$];

        reset_n    = 1'b0;
        dac_tvalid = 1'b0;
        dac_tdata  = '0;
        dac_pd     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_sync_n", 32'(sync_n), 32'd1);
        check_eq("rst_sclk", 32'(sclk), 32'd1);
        check_eq("rst_mosi", 32'(mosi), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_tready", 32'(dac_tready), 32'd1);

        send(16'hA55A, 2'b00, 1'b0);
        expect_frame("single", 24'h00A55A, gap);
        send(16'h0000, 2'b11, 1'b0);
        expect_frame("pd11", 24'h030000, gap);
        send(16'hFFFF, 2'b00, 1'b0);
        expect_frame("ffff", 24'h00FFFF, gap);

        // Back-to-back with tvalid held high.
        acc_q.delete();
        send(16'h1234, 2'b00, 1'b1);
        send(16'h8001, 2'b00, 1'b0);
        expect_frame("b2b0", 24'h001234, gap);
        expect_frame("b2b1", 24'h008001, gap);
        check_eq("b2b_gap", 32'(gap), 32'(SG + 1));
        check_eq("b2b_acc_n", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() == 2)
            check_eq("b2b_spacing", 32'(acc_q[1] - acc_q[0]), 32'(FL + SG + 1));

        // Backpressure: a pulse mid-frame is ignored, a held beat waits for ready.
        acc_q.delete();
        send(16'h5A5A, 2'b01, 1'b0);
        wait_edges(5);
        @(posedge clk);
        #1;
        dac_tdata  = 16'hDEAD;
        dac_tvalid = 1'b1;
        @(posedge clk);
        #1;
        dac_tvalid = 1'b0;
        check_eq("bp_no_accept", 32'(acc_q.size()), 32'd1);
        send(16'hDEAD, 2'b00, 1'b0);
        expect_frame("bp_inflight", 24'h015A5A, gap);
        expect_frame("bp_dead", 24'h00DEAD, gap);
        check_eq("bp_acc_n", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() == 2)
            check_eq("bp_spacing", 32'(acc_q[1] - acc_q[0]), 32'(FL + SG + 1));

        // Mid-frame reset after the 10th falling edge.
        done_before = frames_done;
        send(16'hC3C3, 2'b00, 1'b0);
        wait_edges(10);
        #1 reset_n = 1'b0;
        #1;
        check_eq("mrst_sync_n", 32'(sync_n), 32'd1);
        check_eq("mrst_sclk", 32'(sclk), 32'd1);
        check_eq("mrst_mosi", 32'(mosi), 32'd0);
        check_eq("mrst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check_eq("mrst_tready", 32'(dac_tready), 32'd1);
        repeat (150) @(negedge clk);
        check_eq("mrst_no_resend", 32'(frames_done), 32'(done_before));
        send(16'h0F0F, 2'b00, 1'b0);
        expect_frame("post_rst", 24'h000F0F, gap);

        // Randomized codes, power-down bits, spacing and hold.
        for (int i = 0; i < 16; i++) begin
            d    = 16'($urandom);
            p    = 2'($urandom_range(0, 3));
            hold = (i < 15) && ($urandom_range(0, 1) == 1);
            exp_q.push_back({6'b0, p, d});
            send(d, p, hold);
            if (!hold) repeat ($urandom_range(0, 4)) @(posedge clk);
        end
        for (int i = 0; i < 16; i++) expect_frame("rnd", exp_q.pop_front(), gap);

        repeat (10) @(negedge clk);
        check_eq("frames_total", 32'(frames_done), 32'(sends - 1));
        check_eq("model_cycles", 32'(model_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
